axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-beat AXI3 responder (slave) with an internal word-addressed SRAM.
- Answers the CPU top's AXI master port: read address, read data, write address, write data and write response channels.
- Used as the simulation/FPGA memory model behind the CPU for bring-up without the SoC crossbar.
- Independent read and write engines; one outstanding transaction per direction.

Parameters:
- ID_W, 4, width of arid/rid/awid/wid/bid.
- DEPTH_LOG2, 12, log2 of SRAM depth in 32-bit words (default 16 KiB).
- RD_LAT, 1, cycles from AR handshake to first rvalid assertion; legal range 1..15.

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous active-high reset
- arid  in  ID_W  read ID
- araddr  in  32  read byte address
- arlen  in  8  burst length; only 0 supported
- arsize  in  3  ignored; 32-bit access assumed
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rid  out  ID_W  read ID echo
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last beat
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awid  in  ID_W  write ID
- awaddr  in  32  write byte address
- awlen  in  8  burst length; only 0 supported
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wid  in  ID_W  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  ignored
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bid  out  ID_W  write ID echo
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Clock and reset: one clock, aclk. Reset is synchronous and active-high on areset.
- Reset values: arready, awready, wready, rvalid, bvalid, rlast = 0; rid, rdata, rresp, bid, bresp = 0. SRAM contents are not reset.
- After reset, arready, awready and wready rise the first cycle areset is low.
- Word index: addr[DEPTH_LOG2+1:2]. addr[1:0] are ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid&arready, latch arid, the index and arlen!=0. Go to R_WAIT with latency counter = RD_LAT-1.
  - R_WAIT: arready=0. Counter decrements each cycle. At 0, sample the SRAM, then go to R_RESP.
  - rvalid asserts exactly RD_LAT cycles after the AR handshake cycle.
  - R_RESP: rvalid=1, rlast=1, rid=latched ID. rresp=2'b00 (OKAY); if the latched arlen!=0, rresp=2'b10 (SLVERR) and rdata=0.
  - rdata/rid/rresp stay stable while rvalid&!rready.
  - On rready, drop rvalid and rlast and return to R_IDLE; arready rises the next cycle.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or the same cycle.
  - Once both are held (including same-cycle arrival), the SRAM byte-write per wstrb happens on that clock edge. The FSM enters W_RESP and bvalid=1 the next cycle.
  - awlen!=0: no SRAM write, bresp=2'b10. Otherwise bresp=2'b00. bid=latched awid.
  - W_RESP: awready=wready=0. On bready, drop bvalid and go to W_COLLECT.
  - wstrb=0 is a legal no-op write with an OKAY response.
- Read/write collision: if the write commit and the read sample hit the same word in the same cycle, the read returns the pre-write data. A read sampled any later cycle sees the new data.
- Read and write engines never stall each other.
- Reset mid-transaction: all in-flight state is dropped, outputs return to reset values, SRAM keeps its contents.

Optional Feature:
- Macro: AXI_SRAM_SLAVE_BOUND_CHECK_EN.
- Defined: address bits [31:DEPTH_LOG2+2] are checked. If any is nonzero, the access is out of range:
  - read returns rresp=2'b11 (DECERR) with rdata=0;
  - write is suppressed and returns bresp=2'b11.
  - DECERR takes precedence over SLVERR.
- Undefined: upper address bits are ignored and the SRAM aliases through the whole address space.

Test Plan:
- Write 0xDEADBEEF, wstrb=4'hF, awaddr=0x10, id 3; then read 0x10, id 5 -> bresp=0, bid=3; rdata=0xDEADBEEF, rid=5, rresp=0, rlast=1; rvalid exactly RD_LAT cycles after AR handshake.
- Byte strobes: preload 0x11223344 at 0x20; write 0xAABBCCDD with wstrb=4'b0101 -> read 0x11BB33DD.
- W before AW by 3 cycles, then AW; hold bready=0 for 4 cycles -> one write only; bvalid held with bid/bresp stable; awready=wready=0 until bready.
- rready low 5 cycles during R_RESP -> rdata/rid stable, arready=0; second AR is accepted only after R handshake; arlen=3 -> rresp=2'b10, rdata=0.
- Same-cycle write commit and read sample at 0x40 (old 0x1, new 0x2) -> read returns 0x1; next read returns 0x2. areset asserted while in R_WAIT -> rvalid never rises; arready=1 the cycle after reset drops.
- With AXI_SRAM_SLAVE_BOUND_CHECK_EN, DEPTH_LOG2=12, read 0x0001_0000 -> rresp=2'b11, rdata=0; write there -> bresp=2'b11, word 0 unchanged. Without the macro: write 0x0001_0000 aliases to word 0.

Source files
------------

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// Single-beat AXI3 slave backed by a word-addressed SRAM. Read and write
// engines are independent, each with one outstanding transaction.
//
// Parameters:
//   ID_W       - width of the AXI ID fields
//   DEPTH_LOG2 - log2 of SRAM depth in 32-bit words
//   RD_LAT     - edges from AR handshake to rvalid rising (1..15)
//
// Ports:
//   aclk, areset                  - clock, synchronous active-high reset
//   ar*/r*                        - read address / read data channels
//   aw*/w*/b*                     - write address / data / response channels
//
// Optional feature macro: AXI_SRAM_SLAVE_BOUND_CHECK_EN
//   When defined, addresses with nonzero bits above the SRAM range return
//   DECERR and writes to them are suppressed. When undefined the SRAM
//   aliases through the whole address space.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int unsigned CNT_W = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic       {W_COLLECT, W_RESP}      w_state_e;

    // SRAM storage; never reset
    logic [31:0] mem [2**DEPTH_LOG2];

    // Out-of-range detection for the optional bound check
    logic ar_oob_c;
    logic aw_oob_c;
`ifdef AXI_SRAM_SLAVE_BOUND_CHECK_EN
    assign ar_oob_c = |araddr[31:DEPTH_LOG2+2];
    assign aw_oob_c = |awaddr[31:DEPTH_LOG2+2];
`else
    assign ar_oob_c = 1'b0;
    assign aw_oob_c = 1'b0;
`endif

    // Inputs that carry no meaning for a single-beat 32-bit slave
    logic unused_inputs_c;
    assign unused_inputs_c = ^{arsize, wid, wlast, araddr, awaddr};

    // ---------------- read engine state ----------------
    r_state_e              r_state_q, r_state_d;
    logic [CNT_W-1:0]      r_cnt_q, r_cnt_d;
    logic [ID_W-1:0]       r_id_q, r_id_d;
    logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
    logic                  r_len_err_q, r_len_err_d;
    logic                  r_oob_q, r_oob_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_W-1:0]       rid_q, rid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // ---------------- write engine state ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ID_W-1:0]       w_id_q, w_id_d;
    logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
    logic                  w_len_err_q, w_len_err_d;
    logic                  w_oob_q, w_oob_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_W-1:0]       bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;

    // SRAM write port, driven on the commit cycle
    logic                  mem_we_c;
    logic [DEPTH_LOG2-1:0] mem_widx_c;
    logic [31:0]           mem_wdata_c;
    logic [3:0]            mem_wstrb_c;

    // Read engine next-state and outputs
    always_comb begin
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        r_id_d      = r_id_q;
        r_idx_d     = r_idx_q;
        r_len_err_d = r_len_err_q;
        r_oob_d     = r_oob_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;

        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_id_d      = arid;
                    r_idx_d     = araddr[DEPTH_LOG2+1:2];
                    r_len_err_d = (arlen != 8'd0);
                    r_oob_d     = ar_oob_c;
                    r_cnt_d     = CNT_W'(RD_LAT - 1);
                    r_state_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    // Sampled on the same edge as any write commit, so a
                    // colliding write is seen only by later reads.
                    rvalid_d  = 1'b1;
                    rlast_d   = 1'b1;
                    rid_d     = r_id_q;
                    rdata_d   = (r_len_err_q || r_oob_q) ? 32'd0 : mem[r_idx_q];
                    rresp_d   = r_oob_q     ? RESP_DECERR :
                                r_len_err_q ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    // Write engine next-state, outputs and SRAM commit
    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        w_id_d      = w_id_q;
        w_idx_d     = w_idx_q;
        w_len_err_d = w_len_err_q;
        w_oob_d     = w_oob_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we_c    = 1'b0;
        mem_widx_c  = w_idx_q;
        mem_wdata_c = w_data_q;
        mem_wstrb_c = w_strb_q;

        unique case (w_state_q)
            W_COLLECT: begin
                if (awvalid && awready_q) begin
                    aw_held_d   = 1'b1;
                    w_id_d      = awid;
                    w_idx_d     = awaddr[DEPTH_LOG2+1:2];
                    w_len_err_d = (awlen != 8'd0);
                    w_oob_d     = aw_oob_c;
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                // Commit as soon as both halves are present, including
                // the edge on which the second one arrives.
                if (aw_held_d && w_held_d) begin
                    mem_we_c    = !w_len_err_d && !w_oob_d && !areset;
                    mem_widx_c  = w_idx_d;
                    mem_wdata_c = w_data_d;
                    mem_wstrb_c = w_strb_d;
                    bvalid_d    = 1'b1;
                    bid_d       = w_id_d;
                    bresp_d     = w_oob_d     ? RESP_DECERR :
                                  w_len_err_d ? RESP_SLVERR : RESP_OKAY;
                    aw_held_d   = 1'b0;
                    w_held_d    = 1'b0;
                    w_state_d   = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase

        awready_d = (w_state_d == W_COLLECT) && !aw_held_d;
        wready_d  = (w_state_d == W_COLLECT) && !w_held_d;
    end

    // Control and output registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q   <= R_IDLE;
            r_cnt_q     <= '0;
            r_id_q      <= '0;
            r_idx_q     <= '0;
            r_len_err_q <= 1'b0;
            r_oob_q     <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            w_state_q   <= W_COLLECT;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            w_id_q      <= '0;
            w_idx_q     <= '0;
            w_len_err_q <= 1'b0;
            w_oob_q     <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            r_id_q      <= r_id_d;
            r_idx_q     <= r_idx_d;
            r_len_err_q <= r_len_err_d;
            r_oob_q     <= r_oob_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            w_state_q   <= w_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            w_id_q      <= w_id_d;
            w_idx_q     <= w_idx_d;
            w_len_err_q <= w_len_err_d;
            w_oob_q     <= w_oob_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
        end
    end

    // SRAM byte-lane write
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb_c[b]) begin
                    mem[mem_widx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave with a transaction-level reference model
// (byte-addressed memory image, per-direction expected responses) compared
// against the DUT outputs on every falling edge, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int unsigned ID_W       = 4;
    localparam int unsigned DEPTH_LOG2 = 12;
    localparam int unsigned RD_LAT     = 3;
`ifdef AXI_SRAM_SLAVE_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic            aclk;
    logic            areset;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    axi_sram_slave #(
        .ID_W(ID_W), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)
    ) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [int];

    bit              cmp_en = 0;
    bit              ready_en = 0;
    bit              rd_busy = 0;
    int              rd_age = 0;
    logic [ID_W-1:0] rd_id_m;
    logic [31:0]     rd_addr_m;
    bit              rd_len_m;
    bit              exp_arready = 0;
    bit              exp_rvalid = 0;
    logic [31:0]     exp_rdata = '0;
    logic [ID_W-1:0] exp_rid = '0;
    logic [1:0]      exp_rresp = '0;

    bit              aw_seen = 0;
    bit              w_seen = 0;
    logic [ID_W-1:0] aw_id_m;
    logic [31:0]     aw_addr_m;
    bit              aw_len_m;
    logic [31:0]     w_data_m;
    logic [3:0]      w_strb_m;
    bit              exp_awready = 0;
    bit              exp_wready = 0;
    bit              exp_bvalid = 0;
    logic [ID_W-1:0] exp_bid = '0;
    logic [1:0]      exp_bresp = '0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[DEPTH_LOG2+1:2]);
    endfunction

    function automatic bit addr_oob(input logic [31:0] a);
        return BOUND_EN && (a[31:DEPTH_LOG2+2] != '0);
    endfunction

    function automatic logic [31:0] mem_rd(input int i);
        return mem_m.exists(i) ? mem_m[i] : 32'hxxxx_xxxx;
    endfunction

    // Advance the model by one rising edge using pre-edge inputs
    always @(posedge aclk) begin : model
        logic [31:0] w;
        if (areset) begin
            cmp_en     = 1;
            ready_en   = 0;
            rd_busy    = 0;
            exp_rvalid = 0;
            exp_rdata  = '0;
            exp_rid    = '0;
            exp_rresp  = '0;
            aw_seen    = 0;
            w_seen     = 0;
            exp_bvalid = 0;
            exp_bid    = '0;
            exp_bresp  = '0;
        end else begin
            // read side: response retire, latency, then new request
            if (exp_rvalid && rready) begin
                exp_rvalid = 0;
                rd_busy    = 0;
            end else if (rd_busy && !exp_rvalid) begin
                rd_age++;
                if (rd_age == RD_LAT) begin
                    exp_rvalid = 1;
                    exp_rid    = rd_id_m;
                    if (addr_oob(rd_addr_m)) begin
                        exp_rresp = 2'b11; exp_rdata = '0;
                    end else if (rd_len_m) begin
                        exp_rresp = 2'b10; exp_rdata = '0;
                    end else begin
                        exp_rresp = 2'b00; exp_rdata = mem_rd(widx(rd_addr_m));
                    end
                end
            end
            if (arvalid && exp_arready) begin
                rd_busy   = 1;
                rd_age    = 0;
                rd_id_m   = arid;
                rd_addr_m = araddr;
                rd_len_m  = (arlen != 0);
            end
            // write side: commit after the read sample so collisions see old data
            if (exp_bvalid) begin
                if (bready) exp_bvalid = 0;
            end else begin
                if (awvalid && exp_awready) begin
                    aw_seen = 1; aw_id_m = awid; aw_addr_m = awaddr; aw_len_m = (awlen != 0);
                end
                if (wvalid && exp_wready) begin
                    w_seen = 1; w_data_m = wdata; w_strb_m = wstrb;
                end
                if (aw_seen && w_seen) begin
                    exp_bvalid = 1;
                    exp_bid    = aw_id_m;
                    if (addr_oob(aw_addr_m))  exp_bresp = 2'b11;
                    else if (aw_len_m)        exp_bresp = 2'b10;
                    else begin
                        exp_bresp = 2'b00;
                        w = mem_rd(widx(aw_addr_m));
                        for (int b = 0; b < 4; b++)
                            if (w_strb_m[b]) w[8*b +: 8] = w_data_m[8*b +: 8];
                        mem_m[widx(aw_addr_m)] = w;
                    end
                    aw_seen = 0;
                    w_seen  = 0;
                end
            end
            ready_en = 1;
        end
        exp_arready = ready_en && !rd_busy;
        exp_awready = ready_en && !exp_bvalid && !aw_seen;
        exp_wready  = ready_en && !exp_bvalid && !w_seen;
    end

    // Per-cycle comparison against the model
    always @(negedge aclk) begin : compare
        if (cmp_en) begin
            chk("arready", 32'(arready), 32'(exp_arready));
            chk("awready", 32'(awready), 32'(exp_awready));
            chk("wready",  32'(wready),  32'(exp_wready));
            chk("rvalid",  32'(rvalid),  32'(exp_rvalid));
            chk("rlast",   32'(rlast),   32'(exp_rvalid));
            chk("bvalid",  32'(bvalid),  32'(exp_bvalid));
            if (exp_rvalid) begin
                chk("rdata", rdata, exp_rdata);
                chk("rid",   32'(rid),   32'(exp_rid));
                chk("rresp", 32'(rresp), 32'(exp_rresp));
            end
            if (exp_bvalid) begin
                chk("bid",   32'(bid),   32'(exp_bid));
                chk("bresp", 32'(bresp), 32'(exp_bresp));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [ID_W-1:0] id,
                             input logic [7:0] len, input int aw_dly, input int w_dly,
                             input int bhold, output logic [1:0] resp,
                             output logic [ID_W-1:0] id_o);
        bit aw_done, w_done, aw_hs, w_hs, got;
        aw_done = 0; w_done = 0; got = 0;
        resp = 2'b01; id_o = '0;
        @(posedge aclk); #1;
        awaddr = addr; awid = id; awlen = len;
        wdata = data; wstrb = strb; wid = id; wlast = 1'b1;
        for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
            awvalid = !aw_done && (i >= aw_dly);
            wvalid  = !w_done && (i >= w_dly);
            @(negedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
        if (!(aw_done && w_done)) return;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bvalid) begin got = 1; break; end
        end
        chk("bvalid_seen", 32'(got), 32'd1);
        if (!got) return;
        resp = bresp; id_o = bid;
        repeat (bhold) @(negedge aclk);
        @(posedge aclk); #1 bready = 1;
        @(posedge aclk); #1 bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [ID_W-1:0] id,
                            input logic [7:0] len, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic [ID_W-1:0] id_o, output int lat);
        bit hs, got;
        hs = 0; got = 0; lat = 0;
        data = '0; resp = 2'b01; id_o = '0;
        @(posedge aclk); #1;
        araddr = addr; arid = id; arlen = len; arsize = 3'd2; arvalid = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (arready) begin hs = 1; break; end
            @(posedge aclk); #1;
        end
        chk("ar_handshake_done", 32'(hs), 32'd1);
        if (!hs) begin arvalid = 0; return; end
        @(posedge aclk); #1 arvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge aclk); lat++;
            @(negedge aclk);
            if (rvalid) begin got = 1; break; end
        end
        chk("rvalid_seen", 32'(got), 32'd1);
        if (!got) return;
        data = rdata; resp = rresp; id_o = rid;
        repeat (rhold) @(negedge aclk);
        @(posedge aclk); #1 rready = 1;
        @(posedge aclk); #1 rready = 0;
    endtask

    // Bail out with a report if something hangs well past the test length
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        logic [31:0]     d;
        logic [1:0]      rs;
        logic [ID_W-1:0] ri;
        int              lat;

        areset = 1; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arvalid = 0;
        rready = 0; awid = '0; awaddr = '0; awlen = '0; awvalid = 0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;

        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_outs",    {rdata[15:0], 4'(rid), 2'(rresp), 4'(bid), 2'(bresp), 4'd0}, 32'd0);
        @(negedge aclk);
        chk("post_rst_readies", {29'd0, arready, awready, wready}, 32'h7);

        // basic write then read
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 4'd3, 8'd0, 0, 0, 0, rs, ri);
        chk("wr1_bresp", 32'(rs), 32'd0);
        chk("wr1_bid",   32'(ri), 32'd3);
        axi_read(32'h10, 4'd5, 8'd0, 0, d, rs, ri, lat);
        chk("rd1_data",  d, 32'hDEAD_BEEF);
        chk("rd1_rid",   32'(ri), 32'd5);
        chk("rd1_rresp", 32'(rs), 32'd0);
        chk("rd1_lat",   32'(lat), 32'(RD_LAT));

        // byte strobes
        axi_write(32'h20, 32'h1122_3344, 4'hF, 4'd1, 8'd0, 0, 0, 0, rs, ri);
        axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, 4'd1, 8'd0, 0, 0, 0, rs, ri);
        axi_read(32'h20, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("strb_data", d, 32'h11BB_33DD);

        // W leads AW by 3 cycles, bready held off
        axi_write(32'h30, 32'h1234_5678, 4'hF, 4'd7, 8'd0, 3, 0, 4, rs, ri);
        chk("wlead_bid",   32'(ri), 32'd7);
        chk("wlead_bresp", 32'(rs), 32'd0);
        axi_read(32'h30, 4'd2, 8'd0, 0, d, rs, ri, lat);
        chk("wlead_data", d, 32'h1234_5678);

        // AW leads W, read with rready held low
        axi_write(32'h34, 32'h0F0F_0F0F, 4'hF, 4'd9, 8'd0, 0, 2, 0, rs, ri);
        axi_read(32'h10, 4'd6, 8'd0, 5, d, rs, ri, lat);
        chk("rhold_data", d, 32'hDEAD_BEEF);
        chk("rhold_rid",  32'(ri), 32'd6);
        axi_read(32'h10, 4'd4, 8'd3, 0, d, rs, ri, lat);
        chk("burst_rd_resp", 32'(rs), 32'd2);
        chk("burst_rd_data", d, 32'd0);

        // burst write rejected, no-op strobe write
        axi_write(32'h10, 32'h0, 4'hF, 4'd8, 8'd2, 0, 0, 0, rs, ri);
        chk("burst_wr_resp", 32'(rs), 32'd2);
        axi_write(32'h20, 32'hFFFF_FFFF, 4'h0, 4'd2, 8'd0, 0, 0, 0, rs, ri);
        chk("nostrb_resp", 32'(rs), 32'd0);
        axi_read(32'h10, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("burst_wr_nochange", d, 32'hDEAD_BEEF);
        axi_read(32'h20, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("nostrb_nochange", d, 32'h11BB_33DD);

        // write commit and read sample on the same edge
        axi_write(32'h40, 32'h1, 4'hF, 4'd1, 8'd0, 0, 0, 0, rs, ri);
        @(posedge aclk); #1;
        araddr = 32'h40; arid = 4'd2; arlen = 8'd0; arvalid = 1;
        @(posedge aclk); #1 arvalid = 0;
        repeat (RD_LAT - 1) @(posedge aclk);
        #1;
        awaddr = 32'h40; awid = 4'd1; awlen = 8'd0; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(posedge aclk); #1 awvalid = 0; wvalid = 0;
        @(negedge aclk);
        chk("collide_rvalid", 32'(rvalid), 32'd1);
        chk("collide_old",    rdata, 32'h1);
        chk("collide_bvalid", 32'(bvalid), 32'd1);
        @(posedge aclk); #1 rready = 1; bready = 1;
        @(posedge aclk); #1 rready = 0; bready = 0;
        axi_read(32'h40, 4'd3, 8'd0, 0, d, rs, ri, lat);
        chk("collide_new", d, 32'h2);

        // reset while the read waits on latency
        @(posedge aclk); #1;
        araddr = 32'h10; arid = 4'd9; arlen = 8'd0; arvalid = 1;
        @(posedge aclk); #1 arvalid = 0; areset = 1;
        @(posedge aclk);
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        chk("midrst_arready0", 32'(arready), 32'd0);
        @(negedge aclk);
        chk("midrst_arready1", 32'(arready), 32'd1);
        for (int i = 0; i < RD_LAT + 2; i++) begin
            @(negedge aclk);
            chk("midrst_no_rvalid", 32'(rvalid), 32'd0);
        end
        axi_read(32'h10, 4'd5, 8'd0, 0, d, rs, ri, lat);
        chk("midrst_mem_kept", d, 32'hDEAD_BEEF);

        // upper address bits: decode error or alias
        axi_write(32'h0, 32'h0BAD_F00D, 4'hF, 4'd1, 8'd0, 0, 0, 0, rs, ri);
`ifdef AXI_SRAM_SLAVE_BOUND_CHECK_EN
        axi_read(32'h0001_0000, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("oob_rd_resp", 32'(rs), 32'd3);
        chk("oob_rd_data", d, 32'd0);
        axi_write(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 4'd1, 8'd0, 0, 0, 0, rs, ri);
        chk("oob_wr_resp", 32'(rs), 32'd3);
        axi_read(32'h0, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("oob_word0_kept", d, 32'h0BAD_F00D);
`else
        axi_write(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 4'd1, 8'd0, 0, 0, 0, rs, ri);
        chk("alias_wr_resp", 32'(rs), 32'd0);
        axi_read(32'h0, 4'd1, 8'd0, 0, d, rs, ri, lat);
        chk("alias_word0", d, 32'hCAFE_F00D);
`endif

        repeat (4) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
